cpu_bus_target: RTL
===================

Name: cpu_bus_target

Overview:
- FPGA-side responder to external bus cycles from the target CPU on the shared 16-bit ad bus.
- Decodes one CPU chip-select and latches a word address from ad during the address phase.
- Serves reads from a small internal register file and commits writes with per-byte strobes.
- Register file also has a local FPGA-side port; the top level wires databus_o, databus_oe and databus_i to the ad SB_IO buffers.

Parameters:
CS_IDX, 0, which bit of cpu_ncs selects this block
ADDR_W, 3, word-address width; register file holds 2**ADDR_W 16-bit words
RESET_WORD, 16'h0000, reset value of every register-file word

Ports:
clk_12mhz  input  1  system clock
nrst  input  1  asynchronous active-low reset
cpu_ncs  input  8  CPU chip selects, active low, asynchronous to clk
cpu_nrd  input  1  CPU read strobe, active low
cpu_nwrl_nwr  input  1  CPU low-byte write strobe, active low
cpu_nwrh_nlbs  input  1  CPU high-byte write strobe, active low
databus_i  input  16  sampled ad pins
databus_o  output  16  read data driven onto ad
databus_oe  output  1  ad output enable
loc_addr  input  ADDR_W  local port word address
loc_we  input  1  local write enable
loc_wdata  input  16  local write data
loc_rdata  output  16  local read data, registered, 1-cycle latency
cpu_wr_stb  output  1  1-cycle pulse when a CPU write commits
cpu_wr_addr  output  ADDR_W  address of the last committed CPU write

Behaviour:
- Reset (nrst low, asynchronous):
  - all registers = RESET_WORD; databus_oe=0; databus_o=0; loc_rdata=0; cpu_wr_stb=0; cpu_wr_addr=0; FSM=IDLE.
- Synchronisers: cpu_ncs[CS_IDX], cpu_nrd, cpu_nwrl_nwr and cpu_nwrh_nlbs each pass through 2 flops, reset to 1. All decisions use the synchronised copies (ncs_s, nrd_s, nwrl_s, nwrh_s).
- FSM:
  - IDLE: on ncs_s falling edge, latch addr = databus_i[ADDR_W:1] (word address; bit 0 ignored) -> ADDR.
  - ADDR:
    - nrd_s=0 -> READ.
    - nwrl_s=0 or nwrh_s=0 -> WRITE.
    - ncs_s=1 -> IDLE with no access performed.
    - If nrd_s and a write strobe are both low, READ wins.
  - READ: databus_o=reg[addr] and databus_oe=1, both registered. oe rises the cycle after entry. When nrd_s=1 or ncs_s=1, oe=0 on the next edge -> DONE.
  - WRITE:
    - Each cycle, for every lane whose strobe is low, sample databus_i into wdata[7:0] (nwrl) or wdata[15:8] (nwrh), and set that lane's byte-enable flag.
    - When both strobes are high, or ncs_s=1: commit the flagged lanes to reg[addr], pulse cpu_wr_stb for 1 cycle, set cpu_wr_addr=addr -> DONE.
  - DONE: wait for ncs_s=1 -> IDLE. databus_oe is always 0 outside READ.
- Timing contract: CPU address and data must be stable at least 3 clk_12mhz periods (about 250 ns) around each edge. The CPU is configured with wait states to meet this. Worst case, oe releases 3 cycles after nrd deasserts at the pin.
- Local port:
  - loc_rdata = reg[loc_addr] registered every cycle.
  - loc_we writes the full word.
  - A CPU commit and loc_we to the same address in the same cycle: the CPU value wins. Different addresses both write.
- Reset mid-cycle: oe drops immediately (asynchronously); any partial write is discarded.
- CS deasserted in WRITE with no flagged lane: no commit and no cpu_wr_stb.

Optional Feature:
- CPU_BUS_TARGET_WRCNT_EN defined:
  - Adds a 16-bit counter of committed CPU writes, reset 0, wrapping 16'hFFFF -> 0.
  - The counter is readable by the CPU at word address 2**ADDR_W; the latched address is then ADDR_W+1 bits wide.
  - CPU writes to that address are ignored: no commit and no strobe.
- Undefined: no counter; the address is ADDR_W bits; addresses alias modulo 2**ADDR_W.

Test Plan:
- Reset: release nrst with no bus activity -> databus_oe=0, loc_rdata=16'h0000, cpu_wr_stb never pulses.
- CPU word write: ad=16'h0006 at CS fall, then nwrl and nwrh low with ad=16'hBEEF for 6 clk, then release -> one cpu_wr_stb, cpu_wr_addr=3, loc_addr=3 reads 16'hBEEF.
- CPU byte write: preload reg[1]=16'h1234 via the local port, then CPU write with only nwrh low and ad=16'hAB00 -> reg[1]=16'hAB34.
- CPU read: loc_we writes reg[5]=16'h5A5A, then CPU read at ad=16'h000A -> databus_oe=1, databus_o=16'h5A5A while nrd low; oe=0 within 3 clk after nrd high.
- Collision: CPU commit to addr 2 with 16'h1111 in the same cycle as loc_we addr 2 with 16'h2222 -> reg[2]=16'h1111.
- Abort/counter: CS released during ADDR -> no strobe and no oe. With CPU_BUS_TARGET_WRCNT_EN, three writes then a read at address 2**ADDR_W -> 16'h0003.

Source files
------------

// File: rtl/cpu_bus_target_if.sv
// CPU-side bus bundle for cpu_bus_target: chip selects, strobes and the split ad bus.
// The CPU (or a bench standing in for it) uses the master modport; the target uses slave.
interface cpu_bus_target_if;
    logic [7:0]  cpu_ncs;
    logic        cpu_nrd;
    logic        cpu_nwrl_nwr;
    logic        cpu_nwrh_nlbs;
    logic [15:0] databus_i;
    logic [15:0] databus_o;
    logic        databus_oe;

    modport master (
        output cpu_ncs, cpu_nrd, cpu_nwrl_nwr, cpu_nwrh_nlbs, databus_i,
        input  databus_o, databus_oe
    );

    modport slave (
        input  cpu_ncs, cpu_nrd, cpu_nwrl_nwr, cpu_nwrh_nlbs, databus_i,
        output databus_o, databus_oe
    );
endinterface

// File: rtl/cpu_bus_target.sv
// FPGA-side responder to CPU bus cycles on the shared 16-bit ad bus, backed by a small
// dual-ported register file. Define CPU_BUS_TARGET_WRCNT_EN to add a CPU-readable write counter.
module cpu_bus_target #(
    parameter int unsigned CS_IDX     = 0,
    parameter int unsigned ADDR_W     = 3,
    parameter logic [15:0] RESET_WORD = 16'h0000
) (
    input  logic              clk_12mhz,
    input  logic              nrst,
    cpu_bus_target_if.slave   bus,
    input  logic [ADDR_W-1:0] loc_addr,
    input  logic              loc_we,
    input  logic [15:0]       loc_wdata,
    output logic [15:0]       loc_rdata,
    output logic              cpu_wr_stb,
    output logic [ADDR_W-1:0] cpu_wr_addr
);

`ifdef CPU_BUS_TARGET_WRCNT_EN
    localparam int unsigned AW = ADDR_W + 1;
`else
    localparam int unsigned AW = ADDR_W;
`endif
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t      state, state_nx;
    logic [3:0]  sync1, sync2;
    logic        ncs_q;
    logic        ncs_s, nrd_s, nwrl_s, nwrh_s;
    logic [AW-1:0] addr, addr_nx;
    logic [15:0] wdata, wdata_nx;
    logic [1:0]  be, be_nx;
    logic        commit;
    logic        oe_nx;
    logic        cnt_sel;
    logic [15:0] rd_word;
    logic [ADDR_W-1:0] cpu_idx;
    logic [15:0] regs [DEPTH];
    logic        unused_bits;

    // Only the selected chip-select bit and the address field of ad are decoded.
    assign unused_bits = ^{bus.cpu_ncs, bus.databus_i};

    // Two-flop synchronisers, idle-high so reset looks like "no bus cycle".
    always_ff @(posedge clk_12mhz or negedge nrst) begin
        if (!nrst) begin
            sync1 <= '1;
            sync2 <= '1;
            ncs_q <= 1'b1;
        end else begin
            sync1 <= {bus.cpu_nwrh_nlbs, bus.cpu_nwrl_nwr, bus.cpu_nrd, bus.cpu_ncs[CS_IDX]};
            sync2 <= sync1;
            ncs_q <= sync2[0];
        end
    end

    assign ncs_s  = sync2[0];
    assign nrd_s  = sync2[1];
    assign nwrl_s = sync2[2];
    assign nwrh_s = sync2[3];

    assign cpu_idx = addr[ADDR_W-1:0];

`ifdef CPU_BUS_TARGET_WRCNT_EN
    logic [15:0] wr_cnt;

    assign cnt_sel = (addr == AW'(DEPTH));
    assign rd_word = cnt_sel ? wr_cnt : regs[cpu_idx];

    always_ff @(posedge clk_12mhz or negedge nrst) begin
        if (!nrst) begin
            wr_cnt <= 16'h0000;
        end else if (commit) begin
            wr_cnt <= wr_cnt + 16'd1;
        end
    end
`else
    assign cnt_sel = 1'b0;
    assign rd_word = regs[cpu_idx];
`endif

    always_ff @(posedge clk_12mhz or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            addr  <= '0;
            wdata <= 16'h0000;
            be    <= 2'b00;
        end else begin
            state <= state_nx;
            addr  <= addr_nx;
            wdata <= wdata_nx;
            be    <= be_nx;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_nx = state;
        addr_nx  = addr;
        wdata_nx = wdata;
        be_nx    = be;
        commit   = 1'b0;
        oe_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (ncs_q && !ncs_s) begin
                    addr_nx  = bus.databus_i[AW:1];
                    be_nx    = 2'b00;
                    state_nx = ADDR;
                end
            end
            ADDR: begin
                if (ncs_s) begin
                    state_nx = IDLE;
                end else if (!nrd_s) begin
                    state_nx = READ;
                end else if (!nwrl_s || !nwrh_s) begin
                    state_nx = WRITE;
                end
            end
            READ: begin
                if (nrd_s || ncs_s) begin
                    state_nx = DONE;
                end else begin
                    oe_nx = 1'b1;
                end
            end
            WRITE: begin
                if (!nwrl_s) begin
                    wdata_nx[7:0] = bus.databus_i[7:0];
                    be_nx[0]      = 1'b1;
                end
                if (!nwrh_s) begin
                    wdata_nx[15:8] = bus.databus_i[15:8];
                    be_nx[1]       = 1'b1;
                end
                // Commit uses this cycle's merged lanes so a strobe still low at CS release counts.
                if ((nwrl_s && nwrh_s) || ncs_s) begin
                    commit   = (|be_nx) && !cnt_sel;
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (ncs_s) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_12mhz or negedge nrst) begin
        if (!nrst) begin
            bus.databus_oe <= 1'b0;
            bus.databus_o  <= 16'h0000;
            cpu_wr_stb     <= 1'b0;
            cpu_wr_addr    <= '0;
        end else begin
            bus.databus_oe <= oe_nx;
            if (oe_nx) begin
                bus.databus_o <= rd_word;
            end
            cpu_wr_stb <= commit;
            if (commit) begin
                cpu_wr_addr <= cpu_idx;
            end
        end
    end

    // NOTE: the register file is small enough to reset as flops; a large RAM would not be reset this way.
    always_ff @(posedge clk_12mhz or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs[i] <= RESET_WORD;
            end
            loc_rdata <= 16'h0000;
        end else begin
            loc_rdata <= regs[loc_addr];
            // NOTE: non-blocking updates; the CPU lanes are scheduled after the local word so they win a collision.
            if (loc_we) begin
                regs[loc_addr] <= loc_wdata;
            end
            if (commit) begin
                if (be_nx[0]) begin
                    regs[cpu_idx][7:0] <= wdata_nx[7:0];
                end
                if (be_nx[1]) begin
                    regs[cpu_idx][15:8] <= wdata_nx[15:8];
                end
            end
        end
    end

endmodule
